// File: rtl/mips_regfile_rd.sv
// -----------------------------------------------------------------------------
// mips_regfile_rd
//
// MIPS general-purpose register file: 2**ADDR_WIDTH entries of DATA_WIDTH bits,
// one write port (driven from WB) and two registered read ports (rs/rt for the
// ID-stage operand latches). Read data appears one clock after the address and
// enable are sampled. Entry 0 is hard-wired to zero.
//
// Optional feature (compile-time macro REGFILE_BYPASS_EN):
//   defined   - write-through bypass: a read that hits the index being written
//               on the same edge returns the new write data.
//   undefined - read-before-write: such a read returns the old entry contents.
//   The storage update is identical in both builds.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   asynchronous, active-high reset (clears storage and outputs)
//   we      in   write enable
//   waddr   in   write register index
//   wdata   in   write data
//   re1     in   read enable, port 1 (rs)
//   raddr1  in   read index, port 1
//   rdata1  out  registered read data, port 1 (holds while re1=0)
//   re2     in   read enable, port 2 (rt)
//   raddr2  in   read index, port 2
//   rdata2  out  registered read data, port 2 (holds while re2=0)
// -----------------------------------------------------------------------------
module mips_regfile_rd #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re1,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic                  re2,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    // A write to r0 is discarded, so it never counts as a write at all.
    logic wr_en;
    assign wr_en = we && (waddr != '0);

    // Storage. Every entry is defined from reset so no X can ever reach the
    // datapath, and entry 0 is never written so it stays zero forever.
    // NOTE: this array is reset on purpose, which forces it into flip-flops
    // rather than a RAM macro; only reset a memory when X-free state is a
    // functional requirement, as it is here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: sequential state uses non-blocking assignment so every
                // flop samples pre-edge values regardless of statement order.
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // Value each port would capture on this edge.
    logic [DATA_WIDTH-1:0] rd1_next;
    logic [DATA_WIDTH-1:0] rd2_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        rd1_next = regs[raddr1];
        rd2_next = regs[raddr2];
`ifdef REGFILE_BYPASS_EN
        // Write-through: a same-edge hit on the write index sees the new data.
        // wr_en already excludes r0, so r0 reads are never bypassed.
        if (wr_en && (raddr1 == waddr)) rd1_next = wdata;
        if (wr_en && (raddr2 == waddr)) rd2_next = wdata;
`endif
        // r0 reads as zero by construction; forced here as well so the
        // guarantee does not depend on the storage alone.
        if (raddr1 == '0) rd1_next = '0;
        if (raddr2 == '0) rd2_next = '0;
    end

    // Registered read ports: capture on enable, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            if (re1) rdata1 <= rd1_next;
            if (re2) rdata2 <= rd2_next;
        end
    end

endmodule

// File: tb/tb_mips_regfile_rd.sv
// -----------------------------------------------------------------------------
// tb_mips_regfile_rd
//
// Self-checking bench for mips_regfile_rd. A table of per-cycle vectors with
// hand-derived expected outputs is applied in a loop; expected values are
// pushed to a scoreboard queue when a vector is driven and popped when the
// registered outputs are sampled after the edge. Hand-written sequences cover
// asynchronous reset assertion mid-operation and the first edge after release.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mips_regfile_rd;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          re1;
    logic [AW-1:0] raddr1;
    logic [DW-1:0] rdata1;
    logic          re2;
    logic [AW-1:0] raddr2;
    logic [DW-1:0] rdata2;

    always #5 clk = ~clk;

    mips_regfile_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          re1;
        logic [AW-1:0] raddr1;
        logic          re2;
        logic [AW-1:0] raddr2;
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
    } vec_t;

    typedef struct {
        logic [DW-1:0] exp1;
        logic [DW-1:0] exp2;
        string         tag;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic r1, input logic [AW-1:0] a1,
                         input logic r2, input logic [AW-1:0] a2);
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
    endtask

    // Drive at the falling edge, let the rising edge capture, sample 1ns later.
    task automatic step(input vec_t v, input string tag);
        sb_t e;
        sb_t got;
        @(negedge clk);
        drive(v.we, v.waddr, v.wdata, v.re1, v.raddr1, v.re2, v.raddr2);
        e.exp1 = v.exp1; e.exp2 = v.exp2; e.tag = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: scoreboard empty, got 0x%08h", tag, rdata1);
        end else begin
            got = sb_q.pop_front();
            check({got.tag, "_rdata1"}, rdata1, got.exp1);
            check({got.tag, "_rdata2"}, rdata2, got.exp2);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input logic r1, input logic [AW-1:0] a1,
                                input logic r2, input logic [AW-1:0] a2,
                                input logic [DW-1:0] x1, input logic [DW-1:0] x2);
        vec_t v;
        v.we = w; v.waddr = wa; v.wdata = wd;
        v.re1 = r1; v.raddr1 = a1; v.re2 = r2; v.raddr2 = a2;
        v.exp1 = x1; v.exp2 = x2;
        return v;
    endfunction

    // Watchdog: the run must always end by itself.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d, expected 0", 1);
        $fatal(1, "timeout");
    end

    localparam int NV = 18;
    vec_t vecs [NV];

    initial begin
        logic [DW-1:0] coll_new_or_old;
        logic [DW-1:0] r31_bypass;
`ifdef REGFILE_BYPASS_EN
        coll_new_or_old = 32'h0000_0022;
        r31_bypass      = 32'h0F0F_0F0F;
`else
        coll_new_or_old = 32'h0000_0011;
        r31_bypass      = 32'h8000_0000;
`endif
        //               we  wa     wdata         re1 a1     re2 a2     exp1           exp2
        vecs[0]  = mk(1, 5'd7,  32'h1234_5678, 0, 5'd0,  0, 5'd0,  32'h0,         32'h0);
        vecs[1]  = mk(0, 5'd0,  32'h0,         1, 5'd7,  0, 5'd0,  32'h1234_5678, 32'h0);
        vecs[2]  = mk(1, 5'd0,  32'hFFFF_FFFF, 1, 5'd0,  1, 5'd0,  32'h0,         32'h0);
        vecs[3]  = mk(0, 5'd0,  32'h0,         1, 5'd0,  1, 5'd0,  32'h0,         32'h0);
        vecs[4]  = mk(1, 5'd3,  32'hAAAA_0000, 0, 5'd0,  0, 5'd0,  32'h0,         32'h0);
        vecs[5]  = mk(0, 5'd0,  32'h0,         1, 5'd3,  0, 5'd0,  32'hAAAA_0000, 32'h0);
        vecs[6]  = mk(1, 5'd3,  32'h5555_FFFF, 0, 5'd3,  0, 5'd0,  32'hAAAA_0000, 32'h0);
        vecs[7]  = mk(0, 5'd0,  32'h0,         0, 5'd3,  0, 5'd0,  32'hAAAA_0000, 32'h0);
        vecs[8]  = mk(0, 5'd0,  32'h0,         1, 5'd3,  0, 5'd0,  32'h5555_FFFF, 32'h0);
        vecs[9]  = mk(1, 5'd9,  32'h0000_0011, 0, 5'd0,  0, 5'd0,  32'h5555_FFFF, 32'h0);
        vecs[10] = mk(1, 5'd9,  32'h0000_0022, 0, 5'd0,  1, 5'd9,  32'h5555_FFFF, coll_new_or_old);
        vecs[11] = mk(0, 5'd0,  32'h0,         0, 5'd0,  1, 5'd9,  32'h5555_FFFF, 32'h0000_0022);
        vecs[12] = mk(1, 5'd1,  32'h0000_0001, 0, 5'd0,  0, 5'd0,  32'h5555_FFFF, 32'h0000_0022);
        vecs[13] = mk(1, 5'd31, 32'h8000_0000, 0, 5'd0,  0, 5'd0,  32'h5555_FFFF, 32'h0000_0022);
        vecs[14] = mk(0, 5'd0,  32'h0,         1, 5'd1,  1, 5'd31, 32'h0000_0001, 32'h8000_0000);
        vecs[15] = mk(0, 5'd0,  32'h0,         1, 5'd31, 1, 5'd31, 32'h8000_0000, 32'h8000_0000);
        vecs[16] = mk(1, 5'd31, 32'h0F0F_0F0F, 1, 5'd31, 0, 5'd0,  r31_bypass,    32'h8000_0000);
        vecs[17] = mk(0, 5'd0,  32'h0,         1, 5'd2,  1, 5'd31, 32'h0,         32'h0F0F_0F0F);

        // Power-on reset with garbage-free inputs; outputs must be 0 at once.
        drive(0, '0, '0, 0, '0, 0, '0);
        reset = 1'b1;
        #1;
        check("por_rdata1", rdata1, 32'h0);
        check("por_rdata2", rdata2, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset asserted mid-operation: r5 is written and read back first.
        step(mk(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 0, 5'd0, 32'h0, 32'h0F0F_0F0F), "rst_wr5");
        step(mk(0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF), "rst_rd5");

        // Pending write/read set up, then reset lands between edges.
        @(negedge clk);
        drive(1, 5'd6, 32'h7777_7777, 1, 5'd5, 1, 5'd6);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_rdata1", rdata1, 32'h0);
        check("midrst_rdata2", rdata2, 32'h0);
        // Edges while reset is high must ignore we/re.
        @(posedge clk);
        #1;
        check("inrst_rdata1", rdata1, 32'h0);
        check("inrst_rdata2", rdata2, 32'h0);
        @(negedge clk);
        drive(0, '0, '0, 0, '0, 0, '0);
        reset = 1'b0;

        // First edge after release is a normal edge: write r4 and read r5/r6.
        step(mk(1, 5'd4, 32'hCAFE_F00D, 1, 5'd5, 1, 5'd6, 32'h0, 32'h0), "post_rd56");
        step(mk(0, 5'd0, 32'h0, 1, 5'd4, 0, 5'd0, 32'hCAFE_F00D, 32'h0), "post_rd4");
        // Earlier contents (r7, r31) are gone after reset.
        step(mk(0, 5'd0, 32'h0, 1, 5'd7, 1, 5'd31, 32'h0, 32'h0), "post_rd7_31");

        if (sb_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
